// File: rtl/foc_mul_arbiter.sv
// ----------------------------------------------------------------------------
// foc_mul_arbiter
//
// Shares one pipelined multiplier between N_REQ requesters. The multiplier
// itself is outside this block; the block selects one requester per cycle
// round-robin and drives its operands onto the multiplier. It tags each issued
// operation with the requester id and returns the product to that requester
// once it emerges LAT enabled edges later.
//
// The multiplier and the tag pipeline both advance only when mul_ce=1. mul_ce
// drops whenever the result sitting at the tail of the pipeline is not
// accepted. Products therefore come back in grant order and are never lost
// under backpressure.
//
// Ports
//   clk        in   1          rising-edge clock
//   reset      in   1          asynchronous, active-high reset
//   req_valid  in   N_REQ      per-requester operand valid
//   req_ready  out  N_REQ      one-hot grant, operands taken this cycle
//   req_a      in   N_REQ*DW   operand A, requester i at [i*DW +: DW]
//   req_b      in   N_REQ*DW   operand B, same packing
//   rsp_valid  out  N_REQ      product valid for requester i
//   rsp_ready  in   N_REQ      product accepted by requester i
//   rsp_p      out  2*DW       product, qualified by rsp_valid
//   mul_ce     out  1          clock enable to the shared multiplier
//   mul_din0   out  DW         multiplier operand 0
//   mul_din1   out  DW         multiplier operand 1
//   mul_dout   in   2*DW       multiplier product (LAT enabled edges later)
// ----------------------------------------------------------------------------
module foc_mul_arbiter #(
  parameter int N_REQ = 3,
  parameter int DW    = 15,
  parameter int LAT   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [N_REQ*DW-1:0]   req_a,
  input  logic [N_REQ*DW-1:0]   req_b,
  output logic [N_REQ-1:0]      rsp_valid,
  input  logic [N_REQ-1:0]      rsp_ready,
  output logic [2*DW-1:0]       rsp_p,
  output logic                  mul_ce,
  output logic [DW-1:0]         mul_din0,
  output logic [DW-1:0]         mul_din1,
  input  logic [2*DW-1:0]       mul_dout
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef logic [IW-1:0] id_t;

  typedef struct packed {
    logic vld;
    id_t  id;
  } tag_t;

  // Tag pipeline: stage 0 is loaded on the grant edge. The last stage lines up
  // with mul_dout.
  tag_t r_tag [LAT];
  id_t  r_rr_ptr;

  tag_t w_tail;
  logic w_gnt_vld;
  id_t  w_gnt_id;
  int   w_idx;

  assign w_tail = r_tag[LAT-1];

  // Response side: the tail tag steers the shared product to its owner.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    rsp_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rsp_valid[i] = w_tail.vld && (w_tail.id == id_t'(i));
    end
  end

  // Stall when the tail holds a result that its owner is not taking.
  assign mul_ce = ~|(rsp_valid & ~rsp_ready);
  assign rsp_p  = mul_dout;

  // Round-robin search starting at r_rr_ptr. Nothing is granted while stalled
  // or in reset, so req_ready and the operand buses stay at zero then.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = '0;
    w_idx     = 0;
    if (!reset && mul_ce) begin
      for (int k = 0; k < N_REQ; k++) begin
        w_idx = int'(r_rr_ptr) + k;
        if (w_idx >= N_REQ) begin
          w_idx = w_idx - N_REQ;
        end
        if (!w_gnt_vld && req_valid[w_idx]) begin
          w_gnt_vld = 1'b1;
          w_gnt_id  = id_t'(w_idx);
        end
      end
    end
  end

  // Grant decode and operand mux; idle cycles present zeros to the multiplier.
  always_comb begin
    req_ready = '0;
    mul_din0  = '0;
    mul_din1  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_gnt_vld && (w_gnt_id == id_t'(i))) begin
        req_ready[i] = 1'b1;
        mul_din0     = req_a[i*DW +: DW];
        mul_din1     = req_b[i*DW +: DW];
      end
    end
  end

  // Tag pipeline and round-robin pointer. Both advance only with the
  // multiplier. A completion at the tail and a new grant at stage 0 therefore
  // share the same edge.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state is updated with non-blocking assignments, so every stage
    // samples its predecessor's old value and the shift is order-independent.
    if (reset) begin
      // NOTE: the tag stages are few and narrow, so all of them are reset.
      // That discards every in-flight operation. The product data itself lives
      // in the multiplier and needs no reset, because a cleared valid masks it.
      for (int s = 0; s < LAT; s++) begin
        r_tag[s] <= '0;
      end
      r_rr_ptr <= '0;
    end else if (mul_ce) begin
      r_tag[0] <= '{vld: w_gnt_vld, id: w_gnt_id};
      for (int s = 1; s < LAT; s++) begin
        r_tag[s] <= r_tag[s-1];
      end
      if (w_gnt_vld) begin
        r_rr_ptr <= (w_gnt_id == id_t'(N_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_foc_mul_arbiter.sv
// ----------------------------------------------------------------------------
// tb_foc_mul_arbiter
//
// Drives foc_mul_arbiter together with a behavioural LAT-stage multiplier.
// Every cycle's outputs are compared against a transaction-level model:
//   - a queue of in-flight operations, each carrying an age in enabled edges;
//   - a round-robin pointer updated arithmetically.
// The test runs directed scenarios first and then a randomized phase.
// ----------------------------------------------------------------------------
module tb_foc_mul_arbiter;

  localparam int N   = 3;
  localparam int DW  = 15;
  localparam int LAT = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N*DW-1:0]    req_a;
  logic [N*DW-1:0]    req_b;
  logic [N-1:0]       rsp_valid;
  logic [N-1:0]       rsp_ready;
  logic [2*DW-1:0]    rsp_p;
  logic               mul_ce;
  logic [DW-1:0]      mul_din0;
  logic [DW-1:0]      mul_din1;
  logic [2*DW-1:0]    mul_dout;

  // Stimulus variables, driven with blocking assignments from the initial block.
  logic [DW-1:0]      a_in [N];
  logic [DW-1:0]      b_in [N];

  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*DW +: DW] = a_in[i];
      req_b[i*DW +: DW] = b_in[i];
    end
  end

  foc_mul_arbiter #(.N_REQ(N), .DW(DW), .LAT(LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_p     (rsp_p),
    .mul_ce    (mul_ce),
    .mul_din0  (mul_din0),
    .mul_din1  (mul_din1),
    .mul_dout  (mul_dout)
  );

  // Behavioural shared multiplier: LAT enabled edges from operands to product.
  logic [2*DW-1:0] mpipe [LAT];
  initial begin
    for (int s = 0; s < LAT; s++) mpipe[s] = '0;
  end
  always_ff @(posedge clk) begin
    if (mul_ce) begin
      mpipe[0] <= (2*DW)'(mul_din0) * (2*DW)'(mul_din1);
      for (int s = 1; s < LAT; s++) mpipe[s] <= mpipe[s-1];
    end
  end
  assign mul_dout = mpipe[LAT-1];

  // ---------------- reference model ----------------
  typedef struct {
    int     id;
    longint prod;
    int     age;   // enabled edges since grant
  } op_t;

  op_t q[$];
  int  rr;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs are already set just after a falling edge.
  task automatic cycle();
    logic         tail_v;
    int           tail_id;
    logic         stall;
    int           gnt;
    int           idx;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_rv;
    longint       exp_d0;
    longint       exp_d1;
    #1;
    if (reset) begin
      q.delete();
      rr = 0;
    end
    tail_v  = (q.size() > 0) && (q[0].age == LAT);
    tail_id = tail_v ? q[0].id : 0;
    stall   = tail_v && !rsp_ready[tail_id];
    gnt     = -1;
    if (!reset && !stall) begin
      for (int k = 0; k < N; k++) begin
        idx = (rr + k) % N;
        if (gnt < 0 && req_valid[idx]) gnt = idx;
      end
    end
    exp_ready = '0;
    exp_d0    = 0;
    exp_d1    = 0;
    if (gnt >= 0) begin
      exp_ready[gnt] = 1'b1;
      exp_d0 = longint'(a_in[gnt]);
      exp_d1 = longint'(b_in[gnt]);
    end
    exp_rv = '0;
    if (tail_v) exp_rv[tail_id] = 1'b1;

    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    check("mul_ce",    64'(mul_ce),    64'(!stall));
    check("mul_din0",  64'(mul_din0),  64'(exp_d0));
    check("mul_din1",  64'(mul_din1),  64'(exp_d1));
    if (tail_v) check("rsp_p", 64'(rsp_p), 64'(q[0].prod));

    @(posedge clk);
    if (!reset && !stall) begin
      if (tail_v) void'(q.pop_front());
      foreach (q[j]) q[j].age++;
      if (gnt >= 0) begin
        q.push_back('{id: gnt, prod: longint'(a_in[gnt]) * longint'(b_in[gnt]), age: 1});
        rr = (gnt + 1) % N;
      end
    end
    @(negedge clk);
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      a_in[i] = DW'($urandom);
      b_in[i] = DW'($urandom);
    end
  endtask

  initial begin
    q.delete();
    rr        = 0;
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = '1;
    for (int i = 0; i < N; i++) begin
      a_in[i] = '0;
      b_in[i] = '0;
    end
    @(negedge clk);
    // Reset state.
    cycle();
    cycle();
    reset = 1'b0;

    // Single op: requester 1, 100 x 200.
    a_in[1]   = 15'd100;
    b_in[1]   = 15'd200;
    req_valid = 3'b010;
    cycle();
    req_valid = '0;
    repeat (LAT + 1) cycle();

    // Contention: all three valid continuously.
    req_valid = 3'b111;
    repeat (9) begin
      rand_ops();
      cycle();
    end
    req_valid = '0;
    repeat (LAT + 1) cycle();

    // Backpressure on requester 0 while others keep requesting.
    rsp_ready = 3'b110;
    rand_ops();
    req_valid = 3'b001;
    cycle();
    req_valid = 3'b110;
    repeat (LAT + 4) begin
      rand_ops();
      cycle();
    end
    rsp_ready = '1;
    req_valid = '0;
    repeat (LAT + 3) cycle();

    // Maximum operands.
    a_in[0]   = 15'h7fff;
    b_in[0]   = 15'h7fff;
    req_valid = 3'b001;
    cycle();
    req_valid = '0;
    repeat (LAT + 1) cycle();

    // Reset with two operations in flight.
    rand_ops();
    req_valid = 3'b011;
    cycle();
    cycle();
    req_valid = '0;
    reset     = 1'b1;
    cycle();
    reset     = 1'b0;
    repeat (LAT + 2) cycle();
    req_valid = 3'b111;
    rand_ops();
    cycle();
    req_valid = '0;
    repeat (LAT + 1) cycle();

    // Pointer wrap: only 2, then only 0 and 1.
    rand_ops();
    req_valid = 3'b100;
    cycle();
    req_valid = 3'b011;
    cycle();
    cycle();
    req_valid = '0;
    repeat (LAT + 1) cycle();

    // Randomized traffic with random backpressure.
    repeat (300) begin
      rand_ops();
      req_valid = N'($urandom);
      rsp_ready = N'($urandom) | N'($urandom);
      cycle();
    end
    rsp_ready = '1;
    req_valid = '0;
    repeat (LAT + 2) cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
